// File: rtl/acia_6850.sv
// acia_6850: Motorola 6850 ACIA (88-2SIO style) with an 8N1 UART, 16x rx oversampling and an active-high IRQ
// Ports: clk; reset (async, active high); addr/data_in/rd/we CPU bus (rd/we pre-qualified, edge-detected here);
// data_out registered read data; rx serial in (async, idle high); tx serial out (idle high); irq interrupt request.
// Build option ACIA_RX_FIFO_EN: adds a 4-entry rx FIFO behind the data register; otherwise a single holding register.
module acia_6850 #(
  parameter int CLK_HZ = 25000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       addr,
  input  logic [7:0] data_in,
  input  logic       rd,
  input  logic       we,
  output logic [7:0] data_out,
  input  logic       rx,
  output logic       tx,
  output logic       irq
);
  localparam int DIV_R = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
  localparam int DIV = DIV_R < 1 ? 1 : DIV_R;
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  logic rd_q, we_q;
  logic [1:0] sync_q;
  logic [7:0] ctl_q, ctl_d, dout_q, dout_d, tdr_q, tdr_d;
  logic tdre_q, tdre_d, fe_q, fe_d, ovrn_q, ovrn_d;
  state_t tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [7:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic [2:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [3:0] tx_tick_q, tx_tick_d, rx_tick_q, rx_tick_d;
  logic [PW-1:0] tx_pre_q, tx_pre_d, rx_pre_q, rx_pre_d;
  logic rd_rise, we_rise, mr, tie, rie, rx_rd, rdrf;
  logic tx_tk, tx_end, tx_take, rx_tk, rx_smp, frame_done;
  logic [7:0] rx_head, status;
`ifdef ACIA_RX_FIFO_EN
  logic [7:0] mem_q [4];
  logic [7:0] mem_d [4];
  logic [1:0] wp_q, wp_d, rp_q, rp_d;
  logic [2:0] cnt_q, cnt_d;
  logic push, pop;
  assign rdrf = cnt_q != 3'd0;
  assign rx_head = mem_q[rp_q];
`else
  logic [7:0] rdr_q, rdr_d;
  logic rdrf_q, rdrf_d;
  assign rdrf = rdrf_q;
  assign rx_head = rdr_q;
`endif
  assign rd_rise = rd & ~rd_q;
  assign we_rise = we & ~we_q;
  assign rx_rd = rd_rise & addr;
  assign mr = ctl_q[1:0] == 2'b11;
  assign tie = ctl_q[6:5] == 2'b01;
  assign rie = ctl_q[7];
  assign irq = ~mr & ((rie & (rdrf | ovrn_q)) | (tie & tdre_q));
  assign status = {irq, 1'b0, ovrn_q, fe_q, 2'b00, tdre_q, rdrf};
  assign data_out = dout_q;
  // Master reset overrides the line immediately; the FSM itself idles one clk later.
  assign tx = mr || tx_state_q == IDLE || tx_state_q == STOP || (tx_state_q == DATA && tx_shift_q[0]);
  assign tx_tk = tx_pre_q == PMAX;
  assign rx_tk = rx_pre_q == PMAX;
  assign tx_end = tx_tk && tx_tick_q == 4'hf;
  assign rx_smp = rx_tk && rx_tick_q == 4'd7;
  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d = tx_bit_q;
    tx_tick_d = tx_tk ? tx_tick_q + 4'd1 : tx_tick_q;
    tx_pre_d = tx_tk ? '0 : tx_pre_q + 1'b1;
    tx_take = 1'b0;
    case (tx_state_q)
      IDLE: tx_take = ~tdre_q;
      START: if (tx_end) tx_state_d = DATA;
      DATA: if (tx_end) begin
        tx_shift_d = tx_shift_q >> 1;
        tx_bit_d = tx_bit_q + 3'd1;
        if (tx_bit_q == 3'd7) tx_state_d = STOP;
      end
      STOP: if (tx_end) begin
        tx_state_d = IDLE;
        tx_take = ~tdre_q;
      end
    endcase
    // Taking the next byte straight from STOP keeps back-to-back frames gapless.
    if (mr) begin
      tx_state_d = IDLE;
      tx_take = 1'b0;
    end else if (tx_take) begin
      tx_state_d = START;
      tx_shift_d = tdr_q;
      tx_bit_d = '0;
      tx_tick_d = '0;
      tx_pre_d = '0;
    end
  end
  always_comb begin
    rx_state_d = rx_state_q;
    rx_shift_d = rx_shift_q;
    rx_bit_d = rx_bit_q;
    rx_tick_d = rx_tk ? rx_tick_q + 4'd1 : rx_tick_q;
    rx_pre_d = rx_tk ? '0 : rx_pre_q + 1'b1;
    frame_done = 1'b0;
    // Sampling always happens at tick count 7; the 4-bit counter wraps so later samples land mid-bit.
    case (rx_state_q)
      IDLE: if (!sync_q[1]) begin
        rx_state_d = START;
        rx_tick_d = '0;
        rx_pre_d = '0;
      end
      START: if (rx_smp) begin
        rx_state_d = sync_q[1] ? IDLE : DATA;
        rx_bit_d = '0;
      end
      DATA: if (rx_smp) begin
        rx_shift_d = {sync_q[1], rx_shift_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = STOP;
      end
      STOP: if (rx_smp) begin
        rx_state_d = IDLE;
        frame_done = 1'b1;
      end
    endcase
    if (mr) begin
      rx_state_d = IDLE;
      frame_done = 1'b0;
    end
  end
  always_comb begin
    ctl_d = ctl_q;
    dout_d = rd_rise ? (addr ? rx_head : status) : dout_q;
    tdr_d = tdr_q;
    tdre_d = tdre_q | tx_take;
    fe_d = frame_done ? ~sync_q[1] : fe_q;
    ovrn_d = ovrn_q & ~rx_rd;
    if (we_rise && !addr) begin
      ctl_d = data_in;
      if (mr && data_in[1:0] != 2'b11) tdre_d = 1'b1;
    end
    if (we_rise && addr && !mr) begin
      tdr_d = data_in;
      tdre_d = 1'b0;
    end
`ifdef ACIA_RX_FIFO_EN
    mem_d = mem_q;
    pop = rx_rd && cnt_q != 3'd0;
    push = frame_done && (cnt_q != 3'd4 || pop);
    if (frame_done && !push) ovrn_d = 1'b1;
    if (push) mem_d[wp_q] = rx_shift_q;
    wp_d = push ? wp_q + 2'd1 : wp_q;
    rp_d = pop ? rp_q + 2'd1 : rp_q;
    cnt_d = cnt_q + {2'b00, push} - {2'b00, pop};
`else
    rdr_d = rdr_q;
    // A read in the same cycle frees the register before the new byte lands.
    rdrf_d = rdrf_q & ~rx_rd;
    if (frame_done) begin
      if (rdrf_d) ovrn_d = 1'b1;
      else begin
        rdr_d = rx_shift_q;
        rdrf_d = 1'b1;
      end
    end
`endif
    if (ctl_d[1:0] == 2'b11) begin
      tdre_d = 1'b0;
      fe_d = 1'b0;
      ovrn_d = 1'b0;
`ifdef ACIA_RX_FIFO_EN
      wp_d = '0;
      rp_d = '0;
      cnt_d = '0;
`else
      rdrf_d = 1'b0;
`endif
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q <= 1'b0;
      we_q <= 1'b0;
      sync_q <= 2'b11;
      ctl_q <= 8'h03;
      dout_q <= '0;
      tdr_q <= '0;
      tdre_q <= 1'b0;
      fe_q <= 1'b0;
      ovrn_q <= 1'b0;
      tx_state_q <= IDLE;
      tx_shift_q <= '0;
      tx_bit_q <= '0;
      tx_tick_q <= '0;
      tx_pre_q <= '0;
      rx_state_q <= IDLE;
      rx_shift_q <= '0;
      rx_bit_q <= '0;
      rx_tick_q <= '0;
      rx_pre_q <= '0;
`ifdef ACIA_RX_FIFO_EN
      mem_q <= '{default: '0};
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
`else
      rdr_q <= '0;
      rdrf_q <= 1'b0;
`endif
    end else begin
      rd_q <= rd;
      we_q <= we;
      sync_q <= {sync_q[0], rx};
      ctl_q <= ctl_d;
      dout_q <= dout_d;
      tdr_q <= tdr_d;
      tdre_q <= tdre_d;
      fe_q <= fe_d;
      ovrn_q <= ovrn_d;
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q <= tx_bit_d;
      tx_tick_q <= tx_tick_d;
      tx_pre_q <= tx_pre_d;
      rx_state_q <= rx_state_d;
      rx_shift_q <= rx_shift_d;
      rx_bit_q <= rx_bit_d;
      rx_tick_q <= rx_tick_d;
      rx_pre_q <= rx_pre_d;
`ifdef ACIA_RX_FIFO_EN
      mem_q <= mem_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
`else
      rdr_q <= rdr_d;
      rdrf_q <= rdrf_d;
`endif
    end
  end
endmodule
